// File: rtl/delay_probe.sv
// Latency probe: flushes a path under test with zeros, injects one marker word,
// and counts clock_ena ticks until the marker reappears on the path output.
module delay_probe #(
    parameter int DATA_WIDTH = 18,
    parameter int CNT_WIDTH  = 8,
    parameter int FLUSH_LEN  = 64
) (
    input  logic                  clock,
    input  logic                  aclr_n,
    input  logic                  sclr,
    input  logic                  clock_ena,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] marker,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  delay
);

    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FCW-1:0]        FLUSH_LAST = FCW'(FLUSH_LEN - 1);
    localparam logic [FCW-1:0]        FLUSH_ONE  = FCW'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_INJECT = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [FCW-1:0]          flush_cnt_r;
    logic [CNT_WIDTH-1:0]    lat_cnt_r;
    logic [DATA_WIDTH-1:0]   marker_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    timeout_r;
    logic [CNT_WIDTH-1:0]    delay_r;
    logic                    match_s;

    assign match_s = (rx_data == marker_r);

    // Measurement FSM with all outputs registered.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {FCW{1'b0}};
            lat_cnt_r   <= CNT_ZERO;
            marker_r    <= DATA_ZERO;
            tx_data_r   <= DATA_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            delay_r     <= CNT_ZERO;
        end else if (sclr) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= {FCW{1'b0}};
            lat_cnt_r   <= CNT_ZERO;
            marker_r    <= DATA_ZERO;
            tx_data_r   <= DATA_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            delay_r     <= CNT_ZERO;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                // Start is accepted on any clock, tick or not.
                ST_IDLE: begin
                    if (start) begin
                        marker_r <= marker;
                        if (marker == DATA_ZERO) begin
                            done_r    <= 1'b1;
                            timeout_r <= 1'b1;
                            delay_r   <= CNT_MAX;
                        end else begin
                            state_r     <= ST_FLUSH;
                            busy_r      <= 1'b1;
                            flush_cnt_r <= {FCW{1'b0}};
                        end
                    end
                end
                ST_FLUSH: begin
                    if (clock_ena) begin
                        if (flush_cnt_r == FLUSH_LAST) begin
                            state_r     <= ST_INJECT;
                            tx_data_r   <= marker_r;
                            lat_cnt_r   <= CNT_ZERO;
                            flush_cnt_r <= {FCW{1'b0}};
                        end else begin
                            flush_cnt_r <= flush_cnt_r + FLUSH_ONE;
                        end
                    end
                end
                // A match here can only come from a combinational loopback.
                ST_INJECT: begin
                    if (clock_ena) begin
                        tx_data_r <= DATA_ZERO;
                        if (match_s) begin
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            timeout_r <= 1'b0;
                            delay_r   <= CNT_ZERO;
                        end else begin
                            state_r   <= ST_WAIT;
                            lat_cnt_r <= CNT_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (clock_ena) begin
                        if (match_s) begin
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            timeout_r <= 1'b0;
                            delay_r   <= lat_cnt_r;
                        end else if (lat_cnt_r == CNT_MAX) begin
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            timeout_r <= 1'b1;
                            delay_r   <= CNT_MAX;
                        end else begin
                            lat_cnt_r <= lat_cnt_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    tx_data_r <= DATA_ZERO;
                end
            endcase
        end
    end

    assign tx_data = tx_data_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign timeout = timeout_r;
    assign delay   = delay_r;

endmodule

// File: tb/tb_delay_probe.sv
// Bench for delay_probe: a tick-counting reference model is compared with the
// DUT every clock, plus fixed expectations for the directed scenarios.
module tb_delay_probe;

    localparam int DW = 18;
    localparam int CW = 8;
    localparam int FL = 64;

    logic          clock = 1'b0;
    logic          aclr_n;
    logic          sclr;
    logic          clock_ena;
    logic          start;
    logic [DW-1:0] marker;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] delay;

    int checks = 0;
    int errors = 0;

    int            path_n  = 0;
    bit            tied    = 1'b0;
    int            cur_lat = 0;
    int            ena_mode = 0;
    int            phase   = 0;
    logic [DW-1:0] cur_mk  = '0;
    int            done_cnt = 0;
    int            tx_hits  = 0;
    bit            last_done = 1'b0;

    delay_probe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .FLUSH_LEN(FL)) dut (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .sclr      (sclr),
        .clock_ena (clock_ena),
        .start     (start),
        .marker    (marker),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .delay     (delay)
    );

    always #5 clock = ~clock;

    // Path under test: tick-enabled shift line, zero-delay wire, or tied to 0.
    logic [DW-1:0] sh [0:15];
    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < 16; i++) sh[i] <= '0;
        end else if (clock_ena) begin
            sh[0] <= tx_data;
            for (int i = 1; i < 16; i++) sh[i] <= sh[i-1];
        end
    end
    assign rx_data = tied ? '0 : ((path_n == 0) ? tx_data : sh[path_n-1]);

    // Reference model: the result is due on tick FL+1+latency after acceptance.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_timeout = 1'b0;
    bit [CW-1:0] m_delay = '0;
    bit [DW-1:0] m_mark = '0;
    int          m_ticks = 0;
    int          m_decide = 0;
    int          m_lat = 0;
    always @(posedge clock or negedge aclr_n) begin
        if (!aclr_n || sclr) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_timeout <= 1'b0; m_delay <= '0;
            m_mark <= '0; m_ticks <= 0; m_decide <= 0; m_lat <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    if (marker == '0) begin
                        m_done <= 1'b1; m_timeout <= 1'b1; m_delay <= 8'hFF;
                    end else begin
                        m_busy   <= 1'b1;
                        m_ticks  <= 0;
                        m_mark   <= marker;
                        m_lat    <= cur_lat;
                        m_decide <= FL + 1 + ((cur_lat <= 255) ? cur_lat : 255);
                    end
                end
            end else if (clock_ena) begin
                if (m_ticks + 1 == m_decide) begin
                    m_busy    <= 1'b0;
                    m_done    <= 1'b1;
                    m_timeout <= (m_lat > 255);
                    m_delay   <= (m_lat > 255) ? 8'hFF : CW'(m_lat);
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare on the falling edge, then update clock_ena after the rising edge.
    task automatic step();
        logic [DW-1:0] e_tx;
        @(negedge clock);
        e_tx = (m_busy && m_ticks == FL) ? m_mark : '0;
        chk("tx_data", 32'(tx_data), 32'(e_tx));
        chk("busy",    32'(busy),    32'(m_busy));
        chk("done",    32'(done),    32'(m_done));
        chk("timeout", 32'(timeout), 32'(m_timeout));
        chk("delay",   32'(delay),   32'(m_delay));
        last_done = (done === 1'b1);
        if (last_done) done_cnt++;
        if (cur_mk != '0 && tx_data === cur_mk) tx_hits++;
        @(posedge clock);
        #2;
        phase++;
        case (ena_mode)
            0:       clock_ena = 1'b1;
            1:       clock_ena = (phase % 3 == 0);
            default: clock_ena = 1'($urandom_range(0, 1));
        endcase
    endtask

    // n < 0 selects the tied-to-zero path.
    task automatic measure(input logic [DW-1:0] mk, input int n, input int mode,
                           input bit noisy, output int cyc);
        bit seen;
        tied = (n < 0); path_n = (n < 0) ? 0 : n; cur_lat = (n < 0) ? 1000 : n;
        ena_mode = mode; cur_mk = mk; tx_hits = 0; done_cnt = 0;
        marker = mk; start = 1'b1;
        step();
        start = 1'b0; marker = DW'($urandom);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 4000) begin
            if (noisy && m_busy) begin
                start = 1'($urandom_range(0, 1)); marker = DW'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
            if (last_done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_wait actual=no_done required=done within 4000 clocks");
        end
        step();
    endtask

    initial begin
        int cyc;
        int n;
        int mode;
        logic [DW-1:0] mk;
        aclr_n = 1'b1; sclr = 1'b0; clock_ena = 1'b1; start = 1'b0; marker = '0;
        #1 aclr_n = 1'b0;
        #10;
        chk("rst_tx", 32'(tx_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_delay", 32'(delay), 32'h0);
        @(posedge clock); #2 aclr_n = 1'b1;
        step(); step();

        measure(18'h2A5A5, 5, 0, 1'b0, cyc);
        chk("n5_delay", 32'(delay), 32'd5);
        chk("n5_timeout", 32'(timeout), 32'd0);
        chk("n5_done_count", 32'(done_cnt), 32'd1);
        chk("n5_tx_marker_clocks", 32'(tx_hits), 32'd1);
        chk("n5_clocks_to_done", 32'(cyc), 32'd71);

        measure(18'h00001, 0, 0, 1'b0, cyc);
        chk("n0_delay", 32'(delay), 32'd0);
        chk("n0_done_count", 32'(done_cnt), 32'd1);

        measure(18'h3FFFF, -1, 0, 1'b0, cyc);
        chk("tmo_delay", 32'(delay), 32'hFF);
        chk("tmo_timeout", 32'(timeout), 32'd1);
        chk("tmo_done_count", 32'(done_cnt), 32'd1);

        measure(18'h0, 5, 0, 1'b0, cyc);
        chk("zero_clocks_to_done", 32'(cyc), 32'd1);
        chk("zero_timeout", 32'(timeout), 32'd1);
        chk("zero_delay", 32'(delay), 32'hFF);
        chk("zero_tx_busy", 32'(busy), 32'd0);

        measure(18'h1B00D, 7, 1, 1'b0, cyc);
        chk("n7_gated_delay", 32'(delay), 32'd7);
        chk("n7_gated_timeout", 32'(timeout), 32'd0);

        measure(18'h2A5A5, 5, 0, 1'b1, cyc);
        chk("noisy_delay", 32'(delay), 32'd5);
        chk("noisy_done_count", 32'(done_cnt), 32'd1);

        // Asynchronous reset in WAIT clears the outputs without a clock.
        tied = 1'b0; path_n = 9; cur_lat = 9; ena_mode = 0; cur_mk = 18'h15555;
        marker = 18'h15555; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 200 && !(m_busy && m_ticks >= FL + 3); i++) step();
        chk("pre_aclr_busy", 32'(busy), 32'd1);
        aclr_n = 1'b0;
        #1;
        chk("aclr_tx", 32'(tx_data), 32'h0);
        chk("aclr_busy", 32'(busy), 32'h0);
        chk("aclr_done", 32'(done), 32'h0);
        chk("aclr_timeout", 32'(timeout), 32'h0);
        chk("aclr_delay", 32'(delay), 32'h0);
        step();
        aclr_n = 1'b1;
        step();

        // Synchronous clear during FLUSH aborts without a done pulse.
        marker = 18'h0ABCD; cur_mk = 18'h0ABCD; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        sclr = 1'b1; step(); sclr = 1'b0;
        chk("sclr_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 150; i++) step();
        chk("sclr_no_done", 32'(done_cnt), 32'd0);

        for (int r = 0; r < 12; r++) begin
            mk = DW'($urandom);
            if (mk == '0) mk = 18'h00100;
            if ($urandom_range(0, 7) == 0) mk = '0;
            n = int'($urandom_range(0, 15));
            mode = int'($urandom_range(0, 2));
            measure(mk, n, mode, 1'($urandom_range(0, 1)), cyc);
            chk("rand_delay", 32'(delay), (mk == '0) ? 32'hFF : 32'(n));
            chk("rand_done_count", 32'(done_cnt), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
